// File: rtl/ifetch_predict_pkg.sv
// Shared pipeline configuration for the fetch stage: opcodes, reset PC,
// branch-counter encodings and fetch FSM states.
package ifetch_predict_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;

   typedef enum logic [1:0] {
      CTR_SNT = 2'b00,
      CTR_WNT = 2'b01,
      CTR_WT  = 2'b10,
      CTR_ST  = 2'b11
   } ctr_e;

   typedef enum logic {
      ST_SEQ  = 1'b0,
      ST_SLOT = 1'b1
   } fetch_state_e;

   function automatic logic is_cond_branch(input logic [5:0] op);
      return (op == OP_REGIMM) || (op == OP_BEQ) || (op == OP_BNE) ||
             (op == OP_BLEZ)   || (op == OP_BGTZ);
   endfunction

   function automatic logic is_jump(input logic [5:0] op);
      return (op == OP_J) || (op == OP_JAL);
   endfunction

endpackage

// File: rtl/ifetch_predict_bht.sv
// Branch history table of 2-bit saturating counters: combinational lookup,
// one training port, all entries weakly not-taken on reset.
module fetch_bht
   import ifetch_predict_pkg::*;
#(
   parameter int unsigned IDX_W = 6
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rd_ctr,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   localparam int unsigned DEPTH = 1 << IDX_W;

   logic [1:0] table_q [DEPTH];

   // Read is taken from the registered array, so a same-cycle update at the
   // same index is only visible on the following cycle.
   assign rd_ctr = table_q[rd_idx];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            table_q[i] <= CTR_WNT;
         end
      end else if (upd_valid) begin
         if (upd_taken) begin
            if (table_q[upd_idx] != CTR_ST) table_q[upd_idx] <= table_q[upd_idx] + 2'd1;
         end else begin
            if (table_q[upd_idx] != CTR_SNT) table_q[upd_idx] <= table_q[upd_idx] - 2'd1;
         end
      end
   end

endmodule

// File: rtl/ifetch_predict.sv
// Instruction fetch with predecode-based branch prediction and delay-slot
// handling; results are registered into the IF/ID outputs.
module ifetch_predict
   import ifetch_predict_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int unsigned BHT_IDX_W = 6
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        FLUSH,
   input  logic [31:0] FLUSH_TARGET,
   input  logic        BR_UPD_VALID,
   input  logic [31:0] BR_UPD_PC,
   input  logic        BR_UPD_TAKEN,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic        IMEM_VALID,
   input  logic [31:0] IMEM_DATA,
   output logic [31:0] Instr1_OUT,
   output logic [31:0] Instr_PC_OUT,
   output logic [31:0] Instr_PC_Plus4_OUT,
   output logic        Branch_prediction_OUT,
   output logic [1:0]  Branch_predictions_OUT
);

   fetch_state_e state, state_nxt;
   logic [31:0]  pc, target_q;
   logic [31:0]  pc_plus4, br_target, j_target, pred_target;
   logic [5:0]   opcode;
   logic [15:0]  imm;
   logic [1:0]   bht_ctr, pred_ctr;
   logic         pred_bit, pred_taken, fetch_done;
   logic         unused_upd_bits;

   assign unused_upd_bits = ^{BR_UPD_PC[31:BHT_IDX_W+2], BR_UPD_PC[1:0]};

   fetch_bht #(.IDX_W(BHT_IDX_W)) u_bht (
      .CLK       (CLK),
      .RESET     (RESET),
      .rd_idx    (pc[BHT_IDX_W+1:2]),
      .rd_ctr    (bht_ctr),
      .upd_valid (BR_UPD_VALID),
      .upd_idx   (BR_UPD_PC[BHT_IDX_W+1:2]),
      .upd_taken (BR_UPD_TAKEN)
   );

   assign IMEM_REQ   = !STALL && !FLUSH;
   assign IMEM_ADDR  = pc;
   assign fetch_done = IMEM_REQ && IMEM_VALID;

   assign opcode    = IMEM_DATA[31:26];
   assign imm       = IMEM_DATA[15:0];
   assign pc_plus4  = pc + 32'd4;
   assign br_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
   assign j_target  = {pc_plus4[31:28], IMEM_DATA[25:0], 2'b00};

   // Predecode; a word fetched as a delay slot never carries a prediction.
   always_comb begin
      pred_bit    = 1'b0;
      pred_ctr    = 2'b00;
      pred_taken  = 1'b0;
      pred_target = br_target;
      if (state == ST_SEQ) begin
         if (is_cond_branch(opcode)) begin
            pred_ctr   = bht_ctr;
            pred_bit   = bht_ctr[1];
            pred_taken = bht_ctr[1];
         end else if (is_jump(opcode)) begin
            pred_ctr    = CTR_ST;
            pred_bit    = 1'b1;
            pred_taken  = 1'b1;
            pred_target = j_target;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      if (FLUSH) begin
         state_nxt = ST_SEQ;
      end else if (fetch_done) begin
         case (state)
            ST_SEQ:  if (pred_taken) state_nxt = ST_SLOT;
            ST_SLOT: state_nxt = ST_SEQ;
            default: state_nxt = ST_SEQ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state                  <= ST_SEQ;
         pc                     <= RESET_PC;
         target_q               <= '0;
         Instr1_OUT             <= '0;
         Instr_PC_OUT           <= '0;
         Instr_PC_Plus4_OUT     <= '0;
         Branch_prediction_OUT  <= 1'b0;
         Branch_predictions_OUT <= '0;
      end else begin
         state <= state_nxt;
         if (FLUSH) begin
            pc                     <= FLUSH_TARGET;
            Instr1_OUT             <= '0;
            Instr_PC_OUT           <= '0;
            Instr_PC_Plus4_OUT     <= '0;
            Branch_prediction_OUT  <= 1'b0;
            Branch_predictions_OUT <= '0;
         end else if (!STALL) begin
            if (IMEM_VALID) begin
               Instr1_OUT             <= IMEM_DATA;
               Instr_PC_OUT           <= pc;
               Instr_PC_Plus4_OUT     <= pc_plus4;
               Branch_prediction_OUT  <= pred_bit;
               Branch_predictions_OUT <= pred_ctr;
               if (state == ST_SLOT) pc <= target_q;
               else                  pc <= pc_plus4;
               if (pred_taken) target_q <= pred_target;
            end else begin
               Instr1_OUT             <= '0;
               Instr_PC_OUT           <= '0;
               Instr_PC_Plus4_OUT     <= '0;
               Branch_prediction_OUT  <= 1'b0;
               Branch_predictions_OUT <= '0;
            end
         end
      end
   end

endmodule

// File: doc/ifetch_predict.md
IFETCH_PREDICT -- requirements
Module: ifetch_predict

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00400000, first fetch address after reset.
REQ-002 SHALL have parameter BHT_IDX_W, default 6, log2 of branch-history-table entries.
REQ-003 SHALL have port CLK  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports STALL / FLUSH  input  1 each  hold pipeline / discard and redirect.
REQ-006 SHALL have port FLUSH_TARGET  input  32  redirect PC, used when FLUSH=1.
REQ-007 SHALL have ports BR_UPD_VALID 1, BR_UPD_PC 32, BR_UPD_TAKEN 1  input  resolved-branch training from EX.
REQ-008 SHALL have ports IMEM_REQ output 1, IMEM_ADDR output 32, IMEM_VALID input 1, IMEM_DATA input 32: memory handshake.
REQ-009 SHALL have registered outputs Instr1_OUT 32, Instr_PC_OUT 32, Instr_PC_Plus4_OUT 32, Branch_prediction_OUT 1, Branch_predictions_OUT 2, feeding the IF/ID register.

Function
REQ-010 SHALL drive IMEM_REQ = !STALL && !FLUSH, IMEM_ADDR = PC, combinationally; a fetch completes in any cycle with IMEM_REQ && IMEM_VALID (variable latency, IMEM_REQ held until accepted).
REQ-011 SHALL, on a completing fetch, register at the edge: Instr1_OUT=IMEM_DATA, Instr_PC_OUT=PC, Instr_PC_Plus4_OUT=PC+4 (mod 2^32), prediction fields per REQ-014..016, and advance PC per REQ-017.
REQ-012 SHALL, when IMEM_REQ=1 and IMEM_VALID=0, register a bubble: all outputs 0, PC unchanged.
REQ-013 SHALL, when STALL=1 and FLUSH=0, hold all outputs, PC, and pending-target state unchanged.
REQ-014 SHALL predecode conditional branches (opcode 6'h01, 6'h04-6'h07): counter = BHT[PC[BHT_IDX_W+1:2]]; Branch_predictions_OUT=counter; Branch_prediction_OUT=counter[1]; target = PC+4 + (sign-extended imm16 << 2).
REQ-015 SHALL predict j/jal (opcode 6'h02/6'h03) taken: Branch_prediction_OUT=1, Branch_predictions_OUT=2'b11, target = {PC_plus4[31:28], instr[25:0], 2'b00}.
REQ-016 SHALL output prediction 0 / 2'b00 for all other instructions (including jr/jalr) and for any instruction fetched as a delay slot.
REQ-017 SHALL, after a predicted-taken fetch, set PENDING=1 and latch target, next fetch PC+4 (delay slot); on completion of the delay-slot fetch PC<=target, PENDING<=0; otherwise PC<=PC+4.
REQ-018 SHALL implement FSM SEQ (normal) / SLOT (PENDING=1, fetching delay slot); SEQ->SLOT on predicted-taken completion, SLOT->SEQ on delay-slot completion, any->SEQ on FLUSH.
REQ-019 SHALL, on FLUSH=1 (priority over STALL and fetch), zero all outputs, load PC<=FLUSH_TARGET, clear PENDING, go SEQ.
REQ-020 SHALL, on BR_UPD_VALID=1, saturating-increment (taken) or decrement (not taken) BHT[BR_UPD_PC[BHT_IDX_W+1:2]] regardless of STALL/FLUSH.
REQ-021 SHALL return the pre-update counter when lookup and update hit the same index in the same cycle.

Reset
REQ-022 SHALL, while RESET=0, asynchronously set PC=RESET_PC, PENDING=0, state SEQ, all outputs 0, every BHT entry 2'b01 (weakly not-taken).
REQ-023 SHALL, on reset assertion mid-fetch, abandon the fetch; IMEM_REQ resumes at RESET_PC on the first edge after release.

Structure
REQ-024 SHALL take opcode constants, RESET_PC default, and counter encodings from the shared pipeline config package/include.
REQ-025 SHALL place the counter table in sub-module fetch_bht (one read port, one update port, async reset).

Verification
REQ-026 SHALL cover reset release with IMEM_VALID=1 every cycle -> IMEM_ADDR 0x00400000, 0x00400004, 0x00400008; outputs match each word.
REQ-027 SHALL cover beq at 0x00400010 with imm 16'h0004 and counter forced 2'b10 -> prediction 1/2'b10, next fetches 0x00400014 then 0x00400024.
REQ-028 SHALL cover j 0x0100000 at 0x00400000 -> prediction 1/2'b11, fetches 0x00400004 then 0x00400000.
REQ-029 SHALL cover STALL for 3 cycles mid-stream -> IMEM_REQ=0, outputs and PC frozen, resume at same PC.
REQ-030 SHALL cover FLUSH with FLUSH_TARGET 0x00400100 during SLOT -> outputs zero, PENDING cleared, next fetch 0x00400100.
REQ-031 SHALL cover 4 taken updates to one index from 2'b01 -> counter saturates at 2'b11; 4 not-taken -> 2'b00.
